// File: rtl/imem_pkg.sv
// Shared types and constants for the prefetching instruction memory.
package imem_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_1030;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // Default-width entry layout; the top re-declares it with its own widths.
  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } fifo_entry_t;

endpackage

// File: rtl/imem_prefetch_fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is readable combinationally.
module fetch_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fifo_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wdata,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  T               slots [DEPTH];
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Push into a full FIFO only happens alongside a pop, so the slot being
  // overwritten is the head that is leaving on this same edge.
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= wdata;
  end

  assign head = slots[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/imem_prefetch.sv
// Instruction ROM with fetch-PC generator and prefetch FIFO (valid/ready out).
// Define IMEM_FAULT_EN to build the range check, fault entries and HALT state.
module imem_prefetch
  import imem_pkg::*;
#(
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         ADDR_WIDTH = 10,
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] BASE_ADDR  = PC_WIDTH'(DEFAULT_BASE_ADDR),
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter string               INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  instr_ready,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [PC_WIDTH-1:0]   instr_pc,
  output logic                  fetch_fault
);

  localparam int unsigned ROM_DEPTH = 2 ** ADDR_WIDTH;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [PC_WIDTH-1:0]   pc;
    logic                  fault;
  } entry_t;

  logic [DATA_WIDTH-1:0]         mem [ROM_DEPTH];
  logic [PC_WIDTH-1:0]           fetch_pc;
  logic [ADDR_WIDTH-1:0]         rom_idx;
  logic                          fault_now;
  logic                          run;
  logic                          push;
  logic                          pop;
  logic                          fifo_full;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  entry_t                        push_entry;
  entry_t                        head;

  initial begin
    for (int unsigned i = 0; i < ROM_DEPTH; i++) mem[i] = '0;
  end

`ifdef IMEM_FAULT_EN
  logic [PC_WIDTH-1:0] index;
  fetch_state_t        state_q;
  fetch_state_t        state_d;

  // Full-width offset: the upper bits decide the range check.
  assign index     = fetch_pc - BASE_ADDR;
  assign rom_idx   = index[ADDR_WIDTH-1:0];
  assign fault_now = (fetch_pc < BASE_ADDR) || (index[PC_WIDTH-1:ADDR_WIDTH] != '0);
  assign run       = (state_q == RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid)         state_d = RUN;
    else if (push && fault_now) state_d = HALT;
  end
`else
  // Legacy mapping: offset taken modulo the ROM depth, never faults.
  assign rom_idx   = fetch_pc[ADDR_WIDTH-1:0] - BASE_ADDR[ADDR_WIDTH-1:0];
  assign fault_now = 1'b0;
  assign run       = 1'b1;
`endif

  // Redirect outranks both push and pop; the FIFO is flushed on that edge.
  assign instr_valid = (fifo_count != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign push        = !redirect_valid && run && (!fifo_full || pop);

  always_comb begin
    push_entry.data  = fault_now ? DATA_WIDTH'(NOP_INSTR) : mem[rom_idx];
    push_entry.pc    = fetch_pc;
    push_entry.fault = fault_now;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     fetch_pc <= BASE_ADDR;
    else if (redirect_valid)     fetch_pc <= redirect_pc;
    else if (push && !fault_now) fetch_pc <= fetch_pc + PC_WIDTH'(1);
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .head  (head),
    .count (fifo_count),
    .full  (fifo_full)
  );

  assign instr_data  = instr_valid ? head.data : '0;
  assign instr_pc    = instr_valid ? head.pc   : '0;
  assign fetch_fault = instr_valid && head.fault;

endmodule

// File: tb/tb_imem_prefetch.sv
// Self-checking bench for imem_prefetch against a queue-based fetch model.
module tb_imem_prefetch;

  localparam logic [31:0] BASE = 32'h1030;
  localparam bit FAULT_EN =
`ifdef IMEM_FAULT_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        fetch_fault;

  imem_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [65:0] obs;
  assign obs = {instr_valid, instr_data, instr_pc, fetch_fault};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: a plain queue of fetched words plus the next fetch PC.
  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  logic [31:0] rom [1024];
  ent_t        q [$];
  logic [31:0] mpc;
  bit          halted;

  function automatic void model_reset();
    q.delete();
    mpc    = BASE;
    halted = 1'b0;
  endfunction

  function automatic void model_step();
    logic [31:0] off;
    ent_t        e;
    if (redirect_valid) begin
      q.delete();
      mpc    = redirect_pc;
      halted = 1'b0;
      return;
    end
    if (q.size() != 0 && instr_ready) void'(q.pop_front());
    if (!halted && q.size() < 4) begin
      off = mpc - BASE;
      if (FAULT_EN && (mpc < BASE || off >= 32'd1024)) begin
        e.data = 32'h0; e.pc = mpc; e.fault = 1'b1;
        halted = 1'b1;
      end else begin
        e.data = rom[off % 1024]; e.pc = mpc; e.fault = 1'b0;
        mpc = mpc + 32'd1;
      end
      q.push_back(e);
    end
  endfunction

  function automatic logic [65:0] exp_v();
    if (q.size() == 0) return '0;
    return {1'b1, q[0].data, q[0].pc, q[0].fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    model_reset();
    n_checks++;
    if (obs !== 66'h0) $display("FAIL reset_outputs got %h exp 0", obs);
    else n_pass++;
  endtask

  task automatic test_stream();
    instr_ready = 1'b1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_v()) $display("FAIL stream_model k=%0d got %h exp %h", k, obs, exp_v());
      else n_pass++;
      if (k < 4) begin
        n_checks++;
        if (instr_valid !== 1'b1 || instr_pc !== BASE + k || instr_data !== 32'h2000_0001 + k)
          $display("FAIL stream_word k=%0d got v=%b pc=%h d=%h exp pc=%h d=%h",
                   k, instr_valid, instr_pc, instr_data, BASE + k, 32'h2000_0001 + k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_v()) $display("FAIL bp_hold k=%0d got %h exp %h", k, obs, exp_v());
      else n_pass++;
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== BASE + k || instr_data !== rom[k])
        $display("FAIL bp_order k=%0d got v=%b pc=%h d=%h exp pc=%h d=%h",
                 k, instr_valid, instr_pc, instr_data, BASE + k, rom[k]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (3) tick();
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1038;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (instr_valid !== 1'b0) $display("FAIL redirect_bubble got v=%b exp 0", instr_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h1038 || instr_data !== rom[8])
      $display("FAIL redirect_target got v=%b pc=%h d=%h exp pc=00001038 d=%h",
               instr_valid, instr_pc, instr_data, rom[8]);
    else n_pass++;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_v() || instr_pc < 32'h1038)
        $display("FAIL redirect_stream k=%0d got %h exp %h", k, obs, exp_v());
      else n_pass++;
    end
  endtask

  task automatic test_fault();
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1430;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
`ifdef IMEM_FAULT_EN
    if (instr_valid !== 1'b1 || instr_data !== 32'h0 || instr_pc !== 32'h1430 || fetch_fault !== 1'b1)
      $display("FAIL fault_entry got v=%b d=%h pc=%h f=%b exp v=1 d=0 pc=1430 f=1",
               instr_valid, instr_data, instr_pc, fetch_fault);
`else
    if (instr_valid !== 1'b1 || instr_data !== rom[0] || instr_pc !== 32'h1430 || fetch_fault !== 1'b0)
      $display("FAIL wrap_entry got v=%b d=%h pc=%h f=%b exp v=1 d=%h pc=1430 f=0",
               instr_valid, instr_data, instr_pc, fetch_fault, rom[0]);
`endif
    else n_pass++;
    instr_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      n_checks++;
      if (obs !== exp_v()) $display("FAIL fault_drain k=%0d got %h exp %h", k, obs, exp_v());
      else n_pass++;
`ifdef IMEM_FAULT_EN
      n_checks++;
      if (instr_valid !== 1'b0) $display("FAIL halt_idle k=%0d got v=%b exp 0", k, instr_valid);
      else n_pass++;
`endif
    end
    redirect_valid = 1'b1;
    redirect_pc    = BASE;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== BASE || instr_data !== 32'h2000_0001 || fetch_fault !== 1'b0)
      $display("FAIL fault_resume got v=%b pc=%h d=%h f=%b exp pc=%h d=20000001",
               instr_valid, instr_pc, instr_data, fetch_fault, BASE);
    else n_pass++;
    instr_ready    = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1000;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
`ifdef IMEM_FAULT_EN
    if (instr_pc !== 32'h1000 || fetch_fault !== 1'b1 || instr_data !== 32'h0)
      $display("FAIL below_base got pc=%h d=%h f=%b exp pc=1000 d=0 f=1", instr_pc, instr_data, fetch_fault);
`else
    if (instr_pc !== 32'h1000 || fetch_fault !== 1'b0 || instr_data !== rom[10'h3D0])
      $display("FAIL below_base got pc=%h d=%h f=%b exp pc=1000 d=%h f=0",
               instr_pc, instr_data, fetch_fault, rom[10'h3D0]);
`endif
    else n_pass++;
  endtask

  task automatic test_redirect_full_pop();
    do_reset();
    instr_ready = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (obs !== exp_v() || q.size() != 4) $display("FAIL full_setup got %h exp %h", obs, exp_v());
    else n_pass++;
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1040;
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (obs !== 66'h0) $display("FAIL collide_flush got %h exp 0", obs);
    else n_pass++;
    tick();
    n_checks++;
    if (instr_pc !== 32'h1040 || instr_data !== rom[16])
      $display("FAIL collide_resume got pc=%h d=%h exp pc=00001040 d=%h", instr_pc, instr_data, rom[16]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b1;
    repeat (3) tick();
    @(posedge clk);
    model_step();
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if (obs !== 66'h0) $display("FAIL async_reset got %h exp 0", obs);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== BASE || instr_data !== rom[0])
      $display("FAIL async_restart got v=%b pc=%h d=%h exp pc=%h d=%h",
               instr_valid, instr_pc, instr_data, BASE, rom[0]);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      instr_ready    = ($urandom_range(9, 0) < 7);
      redirect_valid = ($urandom_range(19, 0) == 0);
      if ($urandom_range(1, 0) == 1) redirect_pc = $urandom_range(32'h1438, 32'h141C);
      else                           redirect_pc = $urandom_range(32'h1438, 32'h1028);
      tick();
      n_checks++;
      if (obs !== exp_v()) $display("FAIL random k=%0d got %h exp %h", k, obs, exp_v());
      else n_pass++;
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    for (int i = 0; i < 4; i++) rom[i] = 32'h2000_0001 + i;
    #1;
    for (int i = 0; i < 1024; i++) dut.mem[i] = rom[i];
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fault();
    test_redirect_full_pop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
